ser_rr_sched: RTL and testbench
===============================

Name: ser_rr_sched

Overview:
- Round-robin scheduler that shares one parallel-to-serial serializer (DATA_WIDTH data, mod-length, valid-in, busy-out interface) among NUM_REQ requesters.
- Each requester has a one-deep holding slot. The scheduler picks one pending slot and issues it to the serializer as a single-cycle valid pulse.
- It then tracks the serializer busy flag until the word is finished.
- Words with lengths the serializer rejects are filtered out here. A timeout guards against an issued word that is never accepted.

Parameters:
- DATA_WIDTH, 16, serializer word width.
- NUM_REQ, 4, number of requesters (>= 2).
- START_TIMEOUT, 8, cycles to wait for ser_busy_i to rise after an issue.
- MIN_VALID_LEN, 3, smallest data_mod value the serializer accepts.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- req_data_i  in  NUM_REQ*DATA_WIDTH  flattened request words; slice k is requester k.
- req_mod_i  in  NUM_REQ*$clog2(DATA_WIDTH)  flattened request lengths.
- req_val_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester slot empty.
- ser_data_o  out  DATA_WIDTH  word to serializer.
- ser_mod_o  out  $clog2(DATA_WIDTH)  length to serializer.
- ser_val_o  out  1  single-cycle issue strobe.
- ser_busy_i  in  1  serializer busy.
- grant_id_o  out  $clog2(NUM_REQ)  requester index of the last grant.
- done_o  out  1  pulse: issued word completed.
- reject_o  out  1  pulse: granted word dropped because its length is below MIN_VALID_LEN.
- timeout_o  out  1  pulse: serializer never started.
- busy_o  out  1  scheduler not IDLE.

Behaviour:
- Reset (srst_i=1 at a clock edge):
  - All slots empty, so req_ready_o = all ones.
  - ser_data_o, ser_mod_o, ser_val_o = 0; grant_id_o = 0.
  - done_o, reject_o, timeout_o, busy_o = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - State = IDLE; timeout counter = 0.
  - Reset mid-operation aborts everything and discards pending words.
- Slot capture:
  - req_ready_o[k] = ~pending[k] (combinational).
  - On req_val_i[k] && req_ready_o[k], data and mod are latched and pending[k] is set at that edge.
  - req_val_i[k] while the slot is full is ignored; the requester must hold it.
- Arbitration:
  - Combinational rotating priority. Search starts at pointer+1 and wraps modulo NUM_REQ.
  - The first pending index wins; the pointer is updated to the winner on the grant.
- FSM states: IDLE, WAIT_START, WAIT_DONE.
- IDLE:
  - Grant occurs when any slot is pending and ser_busy_i=0. On the grant, pending[winner] is cleared and grant_id_o <= winner.
  - If mod < MIN_VALID_LEN: reject_o pulses the next cycle, nothing is issued, and the state stays IDLE.
  - Otherwise: ser_data_o/ser_mod_o <= slot contents, ser_val_o=1 for exactly one cycle, counter cleared, state goes to WAIT_START.
- WAIT_START:
  - ser_busy_i=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches START_TIMEOUT, timeout_o pulses and the state goes to IDLE.
- WAIT_DONE:
  - ser_busy_i=0 pulses done_o the next cycle and moves to IDLE.
- Latency and timing:
  - Req accepted at edge N, pending visible N+1, ser_val_o high during cycle N+2 (no contention).
  - A freed slot shows req_ready_o=1 the cycle after the grant.
  - Back-to-back grants: a new grant is possible in the IDLE cycle after done_o is raised.
- busy_o = (state != IDLE), registered.
- ser_data_o and ser_mod_o hold their value until the next issue.

Decomposition:
- ser_sched_pkg holds:
  - the state_t enum (IDLE, WAIT_START, WAIT_DONE);
  - the default MIN_VALID_LEN constant;
  - the index-width localparam helpers.
- One sub-module, rr_arbiter:
  - inputs: pending vector and pointer;
  - outputs: winner index and any-pending flag;
  - purely combinational.

Test Plan:
- Requester 0 sends data 16'hA5C3, mod 5. The serializer model raises busy 1 cycle after ser_val_o and holds it 6 cycles -> ser_val_o high for 1 cycle with A5C3/5, grant_id_o=0, done_o pulses once, req_ready_o[0] back to 1.
- All 4 requesters are valid in the same cycle -> grant_id_o sequence 0,1,2,3. Then requesters 1 and 3 re-request -> grant order 1 then 3.
- Requester 2 sends mod 2 -> reject_o pulses with grant_id_o=2, no ser_val_o, slot 2 freed, state IDLE.
- Serializer model never raises busy, START_TIMEOUT=8 -> timeout_o pulses 8 cycles after ser_val_o, busy_o drops, the next pending word is granted.
- Requester 1 holds valid while its slot is full, with a different word -> second word not captured until req_ready_o[1]=1. Both words are issued in order with no loss or duplication.
- srst_i asserted during WAIT_DONE with 2 slots pending -> next cycle all outputs at reset values, req_ready_o=4'b1111, no done_o, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/ser_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : ser_sched_pkg
// Brief    : Shared types and constants for the round-robin serializer
//            scheduler (FSM state type, default length threshold, width helper).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ser_sched_pkg;

  // Scheduler FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } state_t;

  // Smallest word length the serializer will accept.
  localparam int unsigned C_MIN_VALID_LEN_DEFAULT = 3;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority picker. The search starts one
//            past the pointer and wraps, the first pending index wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         pend_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  assign any_o = |pend_i;

  // Walk from the lowest priority to the highest so the last hit is the winner.
  always_comb begin
    winner_o = '0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (pend_i[cand]) winner_o = cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ser_rr_sched.sv
//------------------------------------------------------------------------------
// Module   : ser_rr_sched
// Brief    : Round-robin scheduler sharing one parallel-to-serial serializer
//            among NUM_REQ requesters, each with a one-deep holding slot.
//            Short words are dropped, a stalled issue times out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ser_rr_sched
  import ser_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int MIN_VALID_LEN = C_MIN_VALID_LEN_DEFAULT
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_data_i,
  input  logic [NUM_REQ*$clog2(DATA_WIDTH)-1:0] req_mod_i,
  input  logic [NUM_REQ-1:0]                    req_val_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  output logic [DATA_WIDTH-1:0]                 ser_data_o,
  output logic [$clog2(DATA_WIDTH)-1:0]         ser_mod_o,
  output logic                                  ser_val_o,
  input  logic                                  ser_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id_o,
  output logic                                  done_o,
  output logic                                  reject_o,
  output logic                                  timeout_o,
  output logic                                  busy_o
);

  localparam int MW = $clog2(DATA_WIDTH);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = idx_width(START_TIMEOUT + 1);

  localparam logic [MW-1:0] C_MIN_LEN  = MW'(MIN_VALID_LEN);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(START_TIMEOUT - 1);

  logic [NUM_REQ-1:0]    pend_q;
  logic [DATA_WIDTH-1:0] slot_data_q [NUM_REQ];
  logic [MW-1:0]         slot_mod_q  [NUM_REQ];
  logic [IW-1:0]         ptr_q;
  state_t                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         grant_id_q;
  logic [DATA_WIDTH-1:0] ser_data_q;
  logic [MW-1:0]         ser_mod_q;
  logic                  ser_val_q, done_q, reject_q, timeout_q, busy_q;

  logic [IW-1:0] winner;
  logic          any_pend;
  logic          grant, win_short, tmo_hit, done_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .pend_i   (pend_q),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_pend)
  );

  assign grant     = (state_q == ST_IDLE) && any_pend && !ser_busy_i;
  assign win_short = slot_mod_q[winner] < C_MIN_LEN;
  assign tmo_hit   = (state_q == ST_WAIT_START) && !ser_busy_i && (cnt_q == C_TMO_LAST);
  assign done_hit  = (state_q == ST_WAIT_DONE) && !ser_busy_i;

  // Holding slots: a grant frees the winner, an empty slot captures a valid word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        slot_data_q[k] <= '0;
        slot_mod_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant && (winner == IW'(k))) begin
          pend_q[k] <= 1'b0;
        end else if (req_val_i[k] && !pend_q[k]) begin
          pend_q[k]      <= 1'b1;
          slot_data_q[k] <= req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          slot_mod_q[k]  <= req_mod_i[k*MW +: MW];
        end
      end
    end
  end

  // Next-state logic: a rejected grant leaves the FSM idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant && !win_short) begin
          state_d = ST_WAIT_START;
          cnt_d   = '0;
        end
      end
      ST_WAIT_START: begin
        if (ser_busy_i)   state_d = ST_WAIT_DONE;
        else if (tmo_hit) state_d = ST_IDLE;
        if (!ser_busy_i)  cnt_d = cnt_q + 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!ser_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers, pointer, serializer-facing outputs and status pulses.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
      grant_id_q <= '0;
      ser_data_q <= '0;
      ser_mod_q  <= '0;
      ser_val_q  <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ser_val_q <= 1'b0;
      reject_q  <= 1'b0;
      done_q    <= done_hit;
      timeout_q <= tmo_hit;
      busy_q    <= (state_d != ST_IDLE);
      if (grant) begin
        ptr_q      <= winner;
        grant_id_q <= winner;
        if (win_short) begin
          reject_q <= 1'b1;
        end else begin
          ser_val_q  <= 1'b1;
          ser_data_q <= slot_data_q[winner];
          ser_mod_q  <= slot_mod_q[winner];
        end
      end
    end
  end

  assign req_ready_o = ~pend_q;
  assign ser_data_o  = ser_data_q;
  assign ser_mod_o   = ser_mod_q;
  assign ser_val_o   = ser_val_q;
  assign grant_id_o  = grant_id_q;
  assign done_o      = done_q;
  assign reject_o    = reject_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ser_rr_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_ser_rr_sched
// Brief    : Scoreboard bench for ser_rr_sched. A transaction-level model
//            predicts each cycle's outputs and queues them, a monitor pops
//            and compares on the falling edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ser_rr_sched;

  localparam int DW   = 16;
  localparam int NR   = 4;
  localparam int TMO  = 8;
  localparam int MINL = 3;
  localparam int MW   = 4;
  localparam int IW   = 2;

  logic               clk_i = 1'b0;
  logic               srst_i;
  logic [NR*DW-1:0]   req_data_i;
  logic [NR*MW-1:0]   req_mod_i;
  logic [NR-1:0]      req_val_i;
  logic [NR-1:0]      req_ready_o;
  logic [DW-1:0]      ser_data_o;
  logic [MW-1:0]      ser_mod_o;
  logic               ser_val_o;
  logic               ser_busy_i;
  logic [IW-1:0]      grant_id_o;
  logic               done_o, reject_o, timeout_o, busy_o;

  always #5 clk_i = ~clk_i;

  ser_rr_sched #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .START_TIMEOUT (TMO),
    .MIN_VALID_LEN (MINL)
  ) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .req_data_i  (req_data_i),
    .req_mod_i   (req_mod_i),
    .req_val_i   (req_val_i),
    .req_ready_o (req_ready_o),
    .ser_data_o  (ser_data_o),
    .ser_mod_o   (ser_mod_o),
    .ser_val_o   (ser_val_o),
    .ser_busy_i  (ser_busy_i),
    .grant_id_o  (grant_id_o),
    .done_o      (done_o),
    .reject_o    (reject_o),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int            cyc;
    logic          sval, rej, done, tmo, busy;
    logic [NR-1:0] ready;
    logic [IW-1:0] gid;
    logic [DW-1:0] sdata;
    logic [MW-1:0] smod;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model state: slot contents, rotation pointer, current job window.
  bit [NR-1:0]   m_pend;
  logic [DW-1:0] m_data [NR];
  logic [MW-1:0] m_mod  [NR];
  int            m_ptr;
  bit            m_active, m_kind_done;
  int            m_end, m_bfrom, m_bto;
  logic [IW-1:0] m_gid;
  logic [DW-1:0] m_sdata;
  logic [MW-1:0] m_smod;

  // Requesters: a held word stays on the bus until the slot takes it.
  bit            r_hold [NR];
  logic [DW-1:0] r_data [NR];
  logic [MW-1:0] r_mod  [NR];

  int f_d = 0, f_l = 0;
  bit f_never = 0, spur_en = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int rr_pick(input bit [NR-1:0] p, input int ptr);
    int idx;
    for (int i = 1; i <= NR; i++) begin
      idx = (ptr + i) % NR;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit any_hold();
    for (int k = 0; k < NR; k++) if (r_hold[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the record queued for this cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_skip cyc=%0d actual=%0d expected=%0d", cyc, cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("ser_val",  ser_val_o,   mon_e.sval);
      chk("reject",   reject_o,    mon_e.rej);
      chk("done",     done_o,      mon_e.done);
      chk("timeout",  timeout_o,   mon_e.tmo);
      chk("busy",     busy_o,      mon_e.busy);
      chk("ready",    req_ready_o, mon_e.ready);
      chk("grant_id", grant_id_o,  mon_e.gid);
      chk("ser_data", ser_data_o,  mon_e.sdata);
      chk("ser_mod",  ser_mod_o,   mon_e.smod);
    end
  end

  // One cycle: choose serializer busy, drive requesters, predict next cycle.
  task automatic step(input bit rst);
    int t, w, d, l;
    bit idle, sb;
    bit [NR-1:0] pb;
    exp_t e;
    t    = cyc;
    idle = !m_active || (t >= m_end);
    if (rst)        sb = 1'b0;
    else if (!idle) sb = (t >= m_bfrom) && (t < m_bto);
    else            sb = spur_en && ($urandom_range(0, 99) < 15);
    srst_i     = rst;
    ser_busy_i = sb;
    for (int k = 0; k < NR; k++) begin
      req_val_i[k]            = r_hold[k];
      req_data_i[k*DW +: DW]  = r_data[k];
      req_mod_i[k*MW +: MW]   = r_mod[k];
    end
    e.cyc = t + 1; e.sval = 0; e.rej = 0; e.done = 0; e.tmo = 0; e.busy = 0;
    if (rst) begin
      m_pend = '0; m_ptr = NR - 1; m_active = 0;
      m_gid = '0; m_sdata = '0; m_smod = '0;
    end else begin
      pb = m_pend;
      for (int k = 0; k < NR; k++) begin
        if (r_hold[k] && !pb[k]) begin
          m_pend[k] = 1'b1; m_data[k] = r_data[k]; m_mod[k] = r_mod[k]; r_hold[k] = 0;
        end
      end
      if (idle && !sb && pb != '0) begin
        w = rr_pick(pb, m_ptr);
        m_pend[w] = 1'b0; m_ptr = w; m_gid = IW'(w);
        if (int'(m_mod[w]) < MINL) begin
          e.rej = 1;
        end else begin
          e.sval = 1; m_sdata = m_data[w]; m_smod = m_mod[w]; m_active = 1;
          if (f_never)      d = TMO;
          else if (f_d > 0) d = f_d;
          else              d = ($urandom_range(0, 3) == 0) ? TMO : $urandom_range(1, TMO - 1);
          l = (f_l > 0) ? f_l : $urandom_range(1, 6);
          if (d < TMO) begin
            m_kind_done = 1; m_bfrom = t + 1 + d; m_bto = m_bfrom + l; m_end = m_bto + 1;
          end else begin
            m_kind_done = 0; m_bfrom = 0; m_bto = 0; m_end = t + 1 + TMO;
          end
        end
      end
      if (m_active && (t + 1 == m_end)) begin
        e.done = m_kind_done; e.tmo = !m_kind_done;
      end
      e.busy = m_active && (t + 1 < m_end);
    end
    e.ready = ~m_pend; e.gid = m_gid; e.sdata = m_sdata; e.smod = m_smod;
    exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic hold(input int k, input logic [DW-1:0] d, input logic [MW-1:0] m);
    r_hold[k] = 1'b1; r_data[k] = d; r_mod[k] = m;
  endtask

  // Run until every word is serviced and the scheduler is idle, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((any_hold() || m_pend != '0 || (m_active && cyc < m_end)) && n < 400) begin
      step(1'b0);
      n++;
    end
    step(1'b0);
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain cyc=%0d actual=%0d expected<%0d", cyc, n, 400);
    end
  endtask

  initial begin
    int n;
    srst_i = 1'b1; req_val_i = '0; req_data_i = '0; req_mod_i = '0; ser_busy_i = 1'b0;
    for (int k = 0; k < NR; k++) begin r_hold[k] = 0; r_data[k] = '0; r_mod[k] = '0; end
    @(negedge clk_i);
    step(1'b1);
    step(1'b1);

    // Single word, serializer busy 1 cycle after issue for 6 cycles.
    f_d = 1; f_l = 6;
    hold(0, 16'hA5C3, 4'd5);
    drain();

    // All four at once, then 1 and 3 again.
    f_l = 2;
    for (int k = 0; k < NR; k++) hold(k, DW'(16'h1000 + k), MW'(4 + k));
    drain();
    hold(1, 16'h2222, 4'd9);
    hold(3, 16'h4444, 4'd15);
    drain();

    // Short length on requester 2, and the exact threshold on requester 0.
    hold(2, 16'hBEEF, 4'd2);
    drain();
    hold(0, 16'h0C0C, 4'd3);
    drain();

    // Serializer never starts: both words time out in turn.
    f_never = 1;
    hold(0, 16'h1111, 4'd7);
    hold(1, 16'h3333, 4'd7);
    drain();
    f_never = 0;

    // Requester 1 presents a second word while its slot is still full.
    hold(1, 16'hAAAA, 4'd6);
    step(1'b0);
    hold(1, 16'h5555, 4'd8);
    drain();

    // Reset during WAIT_DONE with two slots pending.
    f_d = 1; f_l = 20;
    hold(0, 16'h7777, 4'd10);
    n = 0;
    while (!(m_active && cyc >= m_bfrom + 1) && n < 50) begin step(1'b0); n++; end
    hold(1, 16'h8888, 4'd4);
    hold(2, 16'h9999, 4'd4);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    for (int k = 0; k < NR; k++) r_hold[k] = 0;
    step(1'b0);
    hold(2, 16'hCAFE, 4'd5);
    hold(0, 16'hF00D, 4'd5);
    drain();
    f_d = 0; f_l = 0;

    // Randomized traffic with spurious serializer busy and rare resets.
    spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!r_hold[k] && $urandom_range(0, 99) < 25)
          hold(k, DW'($urandom), MW'($urandom_range(0, 15)));
      end
      step($urandom_range(0, 499) == 0);
    end
    spur_en = 0;
    drain();

    @(negedge clk_i);
    @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
